fm_cmn_bram_fifo_ctrl: RTL

Show-ahead FIFO controller that sequences an external dual-port block RAM. The RAM is written on port A (a/di/we) and read on port B (dpra/dpo), with 1-cycle registered read latency and read-first behaviour. The block converts this RAM into a valid/ready FIFO with full 1-word/cycle throughput, using a 2-entry output skid buffer to hide the read latency. It is used as the common buffering element between pipeline stages in fm_cmn.

---
 rtl/fm_cmn_bram_fifo_ctrl_if.sv | 29 ++
 rtl/fm_cmn_bram_fifo_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/fm_cmn_bram_fifo_ctrl_if.sv
// rtl/fm_cmn_bram_fifo_ctrl_if.sv - write/read stream and RAM port bundle for the BRAM FIFO controller
interface fm_cmn_bram_fifo_ctrl_if #(
  parameter int P_WIDTH = 32,
  parameter int P_RANGE = 4
);
  logic               flush;
  logic               wvalid;
  logic               wready;
  logic [P_WIDTH-1:0] wdata;
  logic               rvalid;
  logic               rready;
  logic [P_WIDTH-1:0] rdata;
  logic [P_RANGE+1:0] count;
  logic               ram_we;
  logic [P_RANGE-1:0] ram_a;
  logic [P_WIDTH-1:0] ram_di;
  logic [P_RANGE-1:0] ram_dpra;
  logic [P_WIDTH-1:0] ram_dpo;

  modport master (
    output flush, wvalid, wdata, rready, ram_dpo,
    input  wready, rvalid, rdata, count, ram_we, ram_a, ram_di, ram_dpra
  );

  modport slave (
    input  flush, wvalid, wdata, rready, ram_dpo,
    output wready, rvalid, rdata, count, ram_we, ram_a, ram_di, ram_dpra
  );
endinterface

// File: rtl/fm_cmn_bram_fifo_ctrl.sv
// rtl/fm_cmn_bram_fifo_ctrl.sv - show-ahead FIFO over an external dual-port BRAM with a 2-slot skid buffer
module fm_cmn_bram_fifo_ctrl #(
  parameter int P_WIDTH = 32,
  parameter int P_RANGE = 4,
  parameter int P_DEPTH = 1 << P_RANGE
) (
  input logic                      clk,
  input logic                      rst,
  fm_cmn_bram_fifo_ctrl_if.slave   bus
);
  localparam logic [P_RANGE:0] L_FULL = (P_RANGE+1)'(P_DEPTH);

  logic [P_RANGE-1:0] wptr;
  logic [P_RANGE-1:0] rptr;
  logic [P_RANGE:0]   ram_cnt;
  logic               rd_pend;
  logic [1:0]         out_cnt;
  logic [P_WIDTH-1:0] slot0;
  logic [P_WIDTH-1:0] slot1;

  logic       wr;
  logic       pop;
  logic       issue;
  logic       cap;
  logic [1:0] oc_after;

  assign bus.wready = (ram_cnt != L_FULL) && !bus.flush;
  assign wr         = bus.wvalid && bus.wready;
  assign bus.rvalid = (out_cnt != 2'd0) && !bus.flush;
  assign pop        = bus.rvalid && bus.rready;
  // Only issue a read when the skid buffer is guaranteed a free slot when the data returns.
  assign issue      = (ram_cnt != '0) && !bus.flush &&
                      ((({1'b0, out_cnt} + {2'b00, rd_pend}) <= 3'd1) || pop);
  assign cap        = rd_pend && !bus.flush;
  assign oc_after   = out_cnt - {1'b0, pop};

  assign bus.ram_we   = wr;
  assign bus.ram_a    = wptr;
  assign bus.ram_di   = bus.wdata;
  assign bus.ram_dpra = rptr;
  assign bus.rdata    = slot0;
  assign bus.count    = {1'b0, ram_cnt} + (P_RANGE+2)'(rd_pend) + (P_RANGE+2)'(out_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      out_cnt <= 2'd0;
      slot0   <= '0;
      slot1   <= '0;
    end else if (bus.flush) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      out_cnt <= 2'd0;
      slot0   <= '0;
      slot1   <= '0;
    end else begin
      if (wr)    wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      case ({wr, issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      rd_pend <= issue;
      if (pop) slot0 <= slot1;
      // Returning word lands in the lowest slot left free after this edge's pop.
      if (cap) begin
        if (oc_after == 2'd0) slot0 <= bus.ram_dpo;
        else                  slot1 <= bus.ram_dpo;
      end
      out_cnt <= oc_after + {1'b0, cap};
    end
  end
endmodule
